// File: rtl/softmax_serial_ctrl_pkg.sv
// Shared types and sizing helpers for the serial softmax sequencer.
// Defaults describe the nominal configuration; helpers derive widths from instance parameters.
package softmax_pkg;

  localparam int DEF_N             = 10;
  localparam int DEF_WIDTH         = 16;
  localparam int DEF_NFRAC         = 10;
  localparam int DEF_MEM_WIDTH     = 10;
  localparam int DEF_MEM_NFRAC_EXP = 4;
  localparam int DEF_MEM_NFRAC_INV = 2;
  localparam int DEF_TABLE_WIDTH   = 18;
  localparam int DEF_TABLE_NFRAC   = 10;

  typedef enum logic [2:0] {
    IDLE,
    EXP,
    EXP_DRAIN,
    INV,
    INV_WAIT,
    MUL,
    DONE
  } state_e;

  // Accumulator width (SUM_W): wide enough that summing unsigned table entries cannot overflow.
  function automatic int sum_w(input int table_width);
    return 2 * table_width;
  endfunction

  // INV_SHIFT: aligns the accumulated sum to the invert-table address grid.
  function automatic int inv_shift(input int table_nfrac, input int mem_nfrac_inv);
    return table_nfrac - mem_nfrac_inv;
  endfunction

  // INV_MAX: largest positive invert-table address.
  function automatic int inv_max(input int mem_width);
    return (1 << (mem_width - 1)) - 1;
  endfunction

  // Element counter width.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_serial_ctrl_if.sv
// Vector handshakes and table-ROM ports of the serial softmax sequencer.
// slave is the sequencer's view, master is the environment's view.
interface softmax_serial_ctrl_if
  import softmax_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MEM_WIDTH   = DEF_MEM_WIDTH,
  parameter int TABLE_WIDTH = DEF_TABLE_WIDTH
);

  logic                        in_valid;
  logic                        in_ready;
  logic [N-1:0][WIDTH-1:0]     in_data;
  logic                        exp_rd;
  logic [MEM_WIDTH-1:0]        exp_addr;
  logic [TABLE_WIDTH-1:0]      exp_data;
  logic                        inv_rd;
  logic [MEM_WIDTH-1:0]        inv_addr;
  logic [TABLE_WIDTH-1:0]      inv_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [N-1:0][WIDTH-1:0]     out_data;

  modport slave (
    input  in_valid, in_data, exp_data, inv_data, out_ready,
    output in_ready, exp_rd, exp_addr, inv_rd, inv_addr, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, exp_data, inv_data, out_ready,
    input  in_ready, exp_rd, exp_addr, inv_rd, inv_addr, out_valid, out_data
  );

endinterface

// File: rtl/softmax_serial_ctrl.sv
// Time-multiplexed softmax: serial exp lookups and accumulation through one ROM port,
// one inverse lookup, then N serial normalising multiplies.
module softmax_serial_ctrl
  import softmax_pkg::*;
#(
  parameter int N             = DEF_N,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int NFRAC         = DEF_NFRAC,
  parameter int MEM_WIDTH     = DEF_MEM_WIDTH,
  parameter int MEM_NFRAC_EXP = DEF_MEM_NFRAC_EXP,
  parameter int MEM_NFRAC_INV = DEF_MEM_NFRAC_INV,
  parameter int TABLE_WIDTH   = DEF_TABLE_WIDTH,
  parameter int TABLE_NFRAC   = DEF_TABLE_NFRAC
) (
  input  logic                  clk,
  input  logic                  reset,
  softmax_serial_ctrl_if.slave  io,
  output logic                  busy
);

  localparam int SUM_W     = sum_w(TABLE_WIDTH);
  localparam int INV_SHIFT = inv_shift(TABLE_NFRAC, MEM_NFRAC_INV);
  localparam int INV_MAX   = inv_max(MEM_WIDTH);
  localparam int CNT_W     = cnt_w(N);
  localparam int SH_R      = (NFRAC > MEM_NFRAC_EXP) ? NFRAC - MEM_NFRAC_EXP : 0;
  localparam int SH_L      = (NFRAC < MEM_NFRAC_EXP) ? MEM_NFRAC_EXP - NFRAC : 0;
  localparam int PROD_LO   = 2 * TABLE_NFRAC - NFRAC;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e                        state_q, state_d;
  logic [N-1:0][WIDTH-1:0]       din_q, din_d;
  logic [N-1:0][TABLE_WIDTH-1:0] ebuf_q, ebuf_d;
  logic [SUM_W-1:0]              sum_q, sum_d;
  logic signed [TABLE_WIDTH-1:0] inv_q, inv_d;
  logic [CNT_W-1:0]              k_q, k_d;
  logic [CNT_W-1:0]              cap_q, cap_d;
  logic                          exp_cap_q, exp_cap_d;
  logic                          exp_rd_q, exp_rd_d;
  logic [MEM_WIDTH-1:0]          exp_addr_q, exp_addr_d;
  logic                          inv_rd_q, inv_rd_d;
  logic [MEM_WIDTH-1:0]          inv_addr_q, inv_addr_d;
  logic [N-1:0][WIDTH-1:0]       out_data_q, out_data_d;
  logic signed [SUM_W-1:0]       prod;

  // Input word to exp-table address: rescale the fraction, then wrap to the address width.
  function automatic logic [MEM_WIDTH-1:0] idx(input logic [WIDTH-1:0] x);
    logic signed [63:0] xe;
    xe = 64'(signed'(x));
    xe = (xe >>> SH_R) <<< SH_L;
    return MEM_WIDTH'(xe);
  endfunction

  // Large sums saturate to the top positive invert address rather than wrapping.
  function automatic logic [MEM_WIDTH-1:0] clamp(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] t;
    t = s >> INV_SHIFT;
    if (t > SUM_W'(INV_MAX)) return MEM_WIDTH'(INV_MAX);
    return MEM_WIDTH'(t);
  endfunction

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    ebuf_d     = ebuf_q;
    sum_d      = sum_q;
    inv_d      = inv_q;
    k_d        = k_q;
    cap_d      = cap_q;
    exp_cap_d  = exp_rd_q;
    exp_rd_d   = 1'b0;
    exp_addr_d = exp_addr_q;
    inv_rd_d   = 1'b0;
    inv_addr_d = inv_addr_q;
    out_data_d = out_data_q;
    prod       = SUM_W'(signed'({1'b0, ebuf_q[k_q]})) * SUM_W'(inv_q);

    // ROM data returns one cycle after each strobe; this runs independently of the state.
    if (exp_cap_q) begin
      ebuf_d[cap_q] = io.exp_data;
      sum_d         = sum_q + SUM_W'(io.exp_data);
      cap_d         = cap_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          state_d    = EXP;
          din_d      = io.in_data;
          sum_d      = '0;
          k_d        = '0;
          cap_d      = '0;
          exp_rd_d   = 1'b1;
          exp_addr_d = idx(io.in_data[0]);
        end
      end
      EXP: begin
        if (k_q == LAST) begin
          state_d = EXP_DRAIN;
        end else begin
          k_d        = k_q + 1'b1;
          exp_rd_d   = 1'b1;
          exp_addr_d = idx(din_q[k_q + 1'b1]);
        end
      end
      EXP_DRAIN: begin
        // Last exp word lands this cycle, so the address is taken from the updated sum.
        state_d    = INV;
        inv_rd_d   = 1'b1;
        inv_addr_d = clamp(sum_d);
      end
      INV: state_d = INV_WAIT;
      INV_WAIT: begin
        inv_d   = io.inv_data;
        k_d     = '0;
        state_d = MUL;
      end
      MUL: begin
        out_data_d[k_q] = WIDTH'(prod >>> PROD_LO);
        if (k_q == LAST) state_d = DONE;
        else             k_d = k_q + 1'b1;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      din_q      <= '0;
      ebuf_q     <= '0;
      sum_q      <= '0;
      inv_q      <= '0;
      k_q        <= '0;
      cap_q      <= '0;
      exp_cap_q  <= 1'b0;
      exp_rd_q   <= 1'b0;
      exp_addr_q <= '0;
      inv_rd_q   <= 1'b0;
      inv_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      ebuf_q     <= ebuf_d;
      sum_q      <= sum_d;
      inv_q      <= inv_d;
      k_q        <= k_d;
      cap_q      <= cap_d;
      exp_cap_q  <= exp_cap_d;
      exp_rd_q   <= exp_rd_d;
      exp_addr_q <= exp_addr_d;
      inv_rd_q   <= inv_rd_d;
      inv_addr_q <= inv_addr_d;
      out_data_q <= out_data_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = out_data_q;
  assign io.exp_rd    = exp_rd_q;
  assign io.exp_addr  = exp_addr_q;
  assign io.inv_rd    = inv_rd_q;
  assign io.inv_addr  = inv_addr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_softmax_serial_ctrl.sv
// Directed bench for softmax_serial_ctrl (N=3) with 1-cycle ROM models and a result scoreboard.
// Expected vectors are hand-computed and queued at issue; a monitor pops them on each output handshake.
module tb_softmax_serial_ctrl;
  import softmax_pkg::*;

  localparam int N = 3, WIDTH = 16, NFRAC = 10, MEM_WIDTH = 10;
  localparam int MEM_NFRAC_EXP = 4, MEM_NFRAC_INV = 2, TABLE_WIDTH = 18, TABLE_NFRAC = 10;

  typedef logic [N-1:0][WIDTH-1:0]     vec_t;
  typedef logic [N-1:0][MEM_WIDTH-1:0] avec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   n_res  = 0;
  vec_t sb_q[$];
  logic [TABLE_WIDTH-1:0] exp_rom [1024];
  logic [TABLE_WIDTH-1:0] inv_rom [1024];

  softmax_serial_ctrl_if #(.N(N), .WIDTH(WIDTH), .MEM_WIDTH(MEM_WIDTH), .TABLE_WIDTH(TABLE_WIDTH)) bus ();

  softmax_serial_ctrl #(
    .N(N), .WIDTH(WIDTH), .NFRAC(NFRAC), .MEM_WIDTH(MEM_WIDTH),
    .MEM_NFRAC_EXP(MEM_NFRAC_EXP), .MEM_NFRAC_INV(MEM_NFRAC_INV),
    .TABLE_WIDTH(TABLE_WIDTH), .TABLE_NFRAC(TABLE_NFRAC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.exp_rd) bus.exp_data <= exp_rom[bus.exp_addr];
    if (bus.inv_rd) bus.inv_data <= inv_rom[bus.inv_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2;
    return v;
  endfunction

  function automatic avec_t mka(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
    avec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2;
    return v;
  endfunction

  task automatic load_roms(input logic [TABLE_WIDTH-1:0] eval, input bit overrides);
    for (int a = 0; a < 1024; a++) begin
      exp_rom[a] = eval;
      inv_rom[a] = TABLE_WIDTH'(a + 5);
    end
    if (overrides) begin
      exp_rom[16]   = 18'd2048;
      exp_rom[1008] = 18'd512;
      exp_rom[511]  = 18'd1024;
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    $display("accept: in_data=%h", v);
    bus.in_valid = 1'b0;
    bus.in_data  = {N{16'h5A5A}};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_one(input vec_t v, input avec_t addrs, input logic [9:0] inv_a, input vec_t res);
    sb_q.push_back(res);
    send(v);
    for (int c = 1; c <= 2*N+4; c++) begin
      if (c <= N) begin
        chk($sformatf("exp_rd_c%0d", c), bus.exp_rd, 1);
        chk($sformatf("exp_addr_c%0d", c), bus.exp_addr, addrs[c-1]);
      end
      if (c == N+1) chk("exp_rd_drain", bus.exp_rd, 0);
      if (c == N+2) begin
        chk("inv_rd", bus.inv_rd, 1);
        chk("inv_addr", bus.inv_addr, inv_a);
      end
      if (c == 2*N+3) chk("out_valid_early", bus.out_valid, 0);
      if (c == 2*N+4) chk("out_valid_latency", bus.out_valid, 1);
      if (c < 2*N+4) @(negedge clk);
    end
    @(negedge clk);
    chk("in_ready_after", bus.in_ready, 1);
    chk("out_valid_drop", bus.out_valid, 0);
  endtask

  always begin : monitor
    vec_t e_v;
    @(negedge clk);
    #1;
    if (bus.out_valid && bus.out_ready) begin
      n_res++;
      $display("result %0d: out_data=%h", n_res, bus.out_data);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got %h required no result", bus.out_data);
      end else begin
        e_v = sb_q.pop_front();
        for (int k = 0; k < N; k++) chk($sformatf("out[%0d]", k), bus.out_data[k], e_v[k]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    load_roms(18'd1024, 1'b0);

    // Reset values
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_exp_rd", bus.exp_rd, 0);
    chk("rst_inv_rd", bus.inv_rd, 0);
    chk("rst_exp_addr", bus.exp_addr, 0);
    chk("rst_inv_addr", bus.inv_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);

    // Nominal: sum 3072 -> inv addr 12 -> inv 17
    run_one(mk(16'h0000, 16'h0000, 16'h0000), mka(0, 0, 0), 10'd12, mk(16'd17, 16'd17, 16'd17));

    // Index mapping with distinct table entries: sum 3584 -> addr 14 -> inv 19
    load_roms(18'd1024, 1'b1);
    run_one(mk(16'h0400, 16'hFC00, 16'h7FFF), mka(16, 1008, 511), 10'd14, mk(16'd38, 16'd9, 16'd19));

    // Clamp: sum 393213 -> s 1535 -> addr 511, inv 516 -> 511 after truncation
    load_roms(18'd131071, 1'b0);
    run_one(mk(16'h0040, 16'h1000, 16'hFFFF), mka(1, 64, 1023), 10'd511, mk(16'd511, 16'd511, 16'd511));

    // Backpressure in DONE with a second vector waiting
    load_roms(18'd1024, 1'b1);
    bus.out_ready = 1'b0;
    sb_q.push_back(mk(16'd17, 16'd17, 16'd17));
    send(mk(16'h0000, 16'h0000, 16'h0000));
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", bus.out_valid, 1);
    bus.in_data  = mk(16'h0400, 16'hFC00, 16'h7FFF);
    bus.in_valid = 1'b1;
    sb_q.push_back(mk(16'd38, 16'd9, 16'd19));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_data", bus.out_data, mk(16'd17, 16'd17, 16'd17));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_idle", bus.in_ready, 1);
    chk("bp_out_valid_drop", bus.out_valid, 0);
    @(negedge clk);
    chk("bp_second_accept", busy, 1);
    chk("bp_second_addr", bus.exp_addr, 16);
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset in the third EXP cycle
    send(mk(16'h0400, 16'hFC00, 16'h7FFF));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_exp_rd", bus.exp_rd, 0);
    chk("mid_rst_exp_addr", bus.exp_addr, 0);
    chk("mid_rst_inv_addr", bus.inv_addr, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    run_one(mk(16'h0400, 16'hFC00, 16'h7FFF), mka(16, 1008, 511), 10'd14, mk(16'd38, 16'd9, 16'd19));

    // Back-to-back with in_valid held high
    sb_q.push_back(mk(16'd17, 16'd17, 16'd17));
    sb_q.push_back(mk(16'd38, 16'd9, 16'd19));
    bus.in_data  = mk(16'h0000, 16'h0000, 16'h0000);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_data = mk(16'h0400, 16'hFC00, 16'h7FFF);
    for (int c = 1; c <= 12; c++) begin
      if (c == 9)  chk("b2b_in_ready_busy", bus.in_ready, 0);
      if (c == 10) chk("b2b_out_valid", bus.out_valid, 1);
      if (c == 11) begin
        chk("b2b_in_ready", bus.in_ready, 1);
        chk("b2b_out_valid_drop", bus.out_valid, 0);
      end
      if (c == 12) begin
        chk("b2b_second_accept", busy, 1);
        chk("b2b_second_addr", bus.exp_addr, 16);
      end
      if (c < 12) @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_idle();

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb_q.size(), 0);
    chk("result_count", n_res, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
